// File: rtl/i2c_slave_if.sv
// Application-side handshake of the I2C target: received bytes, transmit byte
// request/supply and the busy indication. The I2C pins stay on the module itself.
interface i2c_slave_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_req;
  logic       busy;

  // The I2C target produces received data and requests. The application supplies tx_byte.
  modport slave (
    output rx_byte,
    output rx_valid,
    output tx_req,
    output busy,
    input  tx_byte
  );

  // The application side.
  modport master (
    input  rx_byte,
    input  rx_valid,
    input  tx_req,
    input  busy,
    output tx_byte
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address. It is fully oversampled: scl and sda are synchronized
// to clk, and every action is keyed off edges detected on the synchronized copies.
// The block never stretches scl. On sda it only pulls low or releases.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned I2C_FREQ   = 100_000
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        scl,
  inout  wire         sda,
  i2c_slave_if.slave  bus_if
);

  // Edge detection needs several clk samples per scl phase.
  if ((CLK_FREQ / I2C_FREQ) < 20) begin : g_ratio_check
    $fatal(1, "i2c_slave: CLK_FREQ/I2C_FREQ must be at least 20");
  end

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StAddr     = 3'd1;
  localparam logic [2:0] StAddrAck  = 3'd2;
  localparam logic [2:0] StWrite    = 3'd3;
  localparam logic [2:0] StWriteAck = 3'd4;
  localparam logic [2:0] StRead     = 3'd5;
  localparam logic [2:0] StReadAck  = 3'd6;
  localparam logic [2:0] StWaitStop = 3'd7;

  // Synchronizer stages (s1, s2) plus a history flop (h) per line.
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;

  logic [2:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       sda_low_q, sda_low_d;
  // In an ACK state: set once the ACK pull-down has started, so the next fall ends it.
  logic       ack_drv_q, ack_drv_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  // Synchronize the bus lines. Reset value is the idle bus level, so reset does not fake an edge.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  // sda may only move while scl is low. A move while scl is steadily high is START or STOP.
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign shift_in  = {shift_q, sda_s2_q};

  // Next-state logic: START/STOP first, then per-state bit handling.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_low_d  = sda_low_q;
    ack_drv_d  = ack_drv_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    if (start_det) begin
      // busy is kept: a repeated START to us keeps the bus claimed.
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      ack_drv_d = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      ack_drv_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = shift_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ack_drv_d = 1'b0;
              if (shift_in[7:1] == SLAVE_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = shift_in[0];
                state_d = StAddrAck;
              end else begin
                busy_d  = 1'b0;
                state_d = StWaitStop;
              end
            end
          end
        end

        StAddrAck: begin
          // On a read, the ACK-bit rise is the cue for the first transmit byte.
          if (scl_rise && ack_drv_q && rw_q) begin
            tx_req_d = 1'b1;
          end
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_low_d = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              if (rw_q) begin
                // This same fall ends the ACK and presents the first data bit.
                state_d    = StRead;
                tx_shift_d = {bus_if.tx_byte[6:0], 1'b0};
                sda_low_d  = ~bus_if.tx_byte[7];
                bit_cnt_d  = 4'd1;
              end else begin
                state_d   = StWrite;
                sda_low_d = 1'b0;
                bit_cnt_d = 4'd0;
              end
            end
          end
        end

        StWrite: begin
          if (scl_rise) begin
            shift_d   = shift_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_byte_d  = shift_in;
              rx_valid_d = 1'b1;
              bit_cnt_d  = 4'd0;
              ack_drv_d  = 1'b0;
              state_d    = StWriteAck;
            end
          end
        end

        StWriteAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_low_d = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              ack_drv_d = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = StWrite;
            end
          end
        end

        StRead: begin
          // bit_cnt counts bits already put on the bus. Zero means load tx_byte at this fall.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              tx_shift_d = {bus_if.tx_byte[6:0], 1'b0};
              sda_low_d  = ~bus_if.tx_byte[7];
              bit_cnt_d  = 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = StReadAck;
            end else begin
              sda_low_d  = ~tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end

        StReadAck: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              tx_req_d  = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = StRead;
            end else begin
              state_d = StWaitStop;
            end
          end
        end

        default: ;  // StIdle and StWaitStop ignore bits until START or STOP.
      endcase
    end
  end

  // State registers. Reset releases sda at once and forgets any transfer in flight.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_shift_q <= 8'd0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_low_q  <= 1'b0;
      ack_drv_q  <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_low_q  <= sda_low_d;
      ack_drv_q  <= ack_drv_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  // Open-drain: pull low or release, never drive high.
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign bus_if.rx_byte  = rx_byte_q;
  assign bus_if.rx_valid = rx_valid_q;
  assign bus_if.tx_req   = tx_req_q;
  assign bus_if.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave. The bench is the I2C initiator. Its model tracks expected
// received bytes, tx_req count, busy and where the target may pull sda. A per-cycle
// compare process checks the DUT against that model.
module tb_i2c_slave;
  localparam logic [6:0] Slv = 7'h50;
  localparam int         Q   = 8;  // clk cycles per quarter scl bit

  logic clk;
  logic arstn;
  logic scl;
  logic m_sda_low;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_if bus_if ();

  i2c_slave #(
    .SLAVE_ADDR (Slv),
    .CLK_FREQ   (4_000_000),
    .I2C_FREQ   (100_000)
  ) dut (
    .clk    (clk),
    .arstn  (arstn),
    .scl    (scl),
    .sda    (sda),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         txreq_seen = 0;
  int         exp_txreq  = 0;
  int         rx_seen    = 0;
  logic       m_busy, busy_chk, slave_window, run_chk;
  logic [7:0] m_rx_last;
  logic [7:0] rx_exp_q[$];
  logic [7:0] dbuf[4];
  logic [7:0] rd_got[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [7:0] e;
    if (arstn === 1'b1 && run_chk) begin
      chk("rx_tx_exclusive", 32'(bus_if.rx_valid & bus_if.tx_req), 32'd0);
      if (bus_if.rx_valid) begin
        rx_seen++;
        chk("rx_valid_expected", 32'(rx_exp_q.size() != 0), 32'd1);
        if (rx_exp_q.size() != 0) begin
          e = rx_exp_q.pop_front();
          chk("rx_byte", 32'(bus_if.rx_byte), 32'(e));
          m_rx_last = e;
        end
      end else begin
        chk("rx_byte_hold", 32'(bus_if.rx_byte), 32'(m_rx_last));
      end
      if (bus_if.tx_req) txreq_seen++;
      if (busy_chk) chk("busy", 32'(bus_if.busy), 32'(m_busy));
      if (!m_sda_low && !slave_window) chk("sda_released", 32'(sda), 32'd1);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One scl bit, entered right after scl fell. 'win' marks whether the target may pull sda.
  task automatic clock_bit(input logic drive_low, input logic win, output logic smp);
    if (win) slave_window = 1'b1;
    wait_clk(Q);
    slave_window = win;
    m_sda_low    = drive_low;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    smp = sda;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_restart();
    wait_clk(Q);
    slave_window = 1'b0;
    m_sda_low    = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    busy_chk = 1'b0;
    wait_clk(Q);
    slave_window = 1'b0;
    m_sda_low    = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_busy   = 1'b0;
    busy_chk = 1'b1;
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, output logic ack);
    logic [7:0] b;
    logic       s, match;
    b        = {a, rw};
    match    = (a == Slv);
    busy_chk = 1'b0;
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], 1'b0, s);
    clock_bit(1'b0, match, s);
    ack = ~s;
    chk("addr_ack", 32'(ack), 32'(match));
    m_busy   = match;
    busy_chk = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic match, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && match) rx_exp_q.push_back(d);
      clock_bit(~d[i], 1'b0, s);
    end
    clock_bit(1'b0, match, s);
    ack = ~s;
    chk("data_ack", 32'(ack), 32'(match));
  endtask

  task automatic write_partial(input logic [7:0] d, input int k);
    logic s;
    for (int i = 7; i >= 8 - k; i--) clock_bit(~d[i], 1'b0, s);
  endtask

  // Read n bytes from dbuf[]. The master ACKs every byte but the last.
  task automatic read_body(input int n);
    logic       s;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        clock_bit(1'b0, 1'b1, s);
        d[j] = s;
      end
      rd_got[i] = d;
      chk("read_data", 32'(d), 32'(dbuf[i]));
      if (i < n - 1) bus_if.tx_byte = dbuf[i + 1];
      clock_bit(i < n - 1, 1'b0, s);
    end
  endtask

  task automatic rand_txn();
    int         segs, n;
    logic [6:0] a;
    logic       rw, ack, last_wr_match;
    last_wr_match = 1'b0;
    bus_start();
    segs = ($urandom_range(0, 3) == 0) ? 2 : 1;
    for (int g = 0; g < segs; g++) begin
      if (g > 0) bus_restart();
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : Slv;
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom_range(0, 255));
      last_wr_match = 1'b0;
      if (a == Slv && rw) begin
        bus_if.tx_byte = dbuf[0];
        send_addr(a, 1'b1, ack);
        exp_txreq += n;
        read_body(n);
      end else begin
        send_addr(a, rw, ack);
        for (int i = 0; i < n; i++) write_byte(dbuf[i], a == Slv && !rw, ack);
        last_wr_match = (a == Slv && !rw);
      end
    end
    if (last_wr_match && $urandom_range(0, 4) == 0)
      write_partial(8'($urandom_range(0, 255)), $urandom_range(1, 7));
    bus_stop();
    chk("rnd_tx_req_count", 32'(txreq_seen), 32'(exp_txreq));
    chk("rnd_rx_drained", 32'(rx_exp_q.size()), 32'd0);
  endtask

  initial begin
    logic ack, s;
    int   rx0, tx0;
    logic [7:0] b;

    arstn = 1'b0;  scl = 1'b1;  m_sda_low = 1'b0;  slave_window = 1'b0;
    busy_chk = 1'b0;  run_chk = 1'b0;  m_busy = 1'b0;  m_rx_last = 8'h00;
    bus_if.tx_byte = 8'h00;
    wait_clk(3);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    chk("rst_tx_req", 32'(bus_if.tx_req), 32'd0);
    chk("rst_rx_byte", 32'(bus_if.rx_byte), 32'h00);
    arstn = 1'b1;
    wait_clk(4);
    run_chk = 1'b1;  busy_chk = 1'b1;

    // Write 0x3C to our address.
    rx0 = rx_seen;
    bus_start();
    send_addr(Slv, 1'b0, ack);
    chk("lit_wr_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h3C, 1'b1, ack);
    chk("lit_wr_data_ack", 32'(ack), 32'd1);
    chk("lit_busy_in_xfer", 32'(bus_if.busy), 32'd1);
    bus_stop();
    chk("lit_rx_byte", 32'(bus_if.rx_byte), 32'h3C);
    chk("lit_rx_pulses", 32'(rx_seen - rx0), 32'd1);
    chk("lit_busy_after_stop", 32'(bus_if.busy), 32'd0);

    // Read two bytes, ACK then NACK.
    tx0 = txreq_seen;
    dbuf[0] = 8'h96;  dbuf[1] = 8'h5A;
    bus_if.tx_byte = dbuf[0];
    bus_start();
    send_addr(Slv, 1'b1, ack);
    exp_txreq += 2;
    read_body(2);
    bus_stop();
    chk("lit_read0", 32'(rd_got[0]), 32'h96);
    chk("lit_read1", 32'(rd_got[1]), 32'h5A);
    chk("lit_tx_req_pulses", 32'(txreq_seen - tx0), 32'd2);

    // Wrong address: no ACK, no data, not busy.
    rx0 = rx_seen;
    bus_start();
    send_addr(7'h51, 1'b0, ack);
    chk("lit_miss_addr_ack", 32'(ack), 32'd0);
    write_byte(8'hFF, 1'b0, ack);
    chk("lit_miss_busy", 32'(bus_if.busy), 32'd0);
    bus_stop();
    chk("lit_miss_rx", 32'(rx_seen - rx0), 32'd0);

    // Write 0x11, repeated START, read 0xC3.
    bus_start();
    send_addr(Slv, 1'b0, ack);
    write_byte(8'h11, 1'b1, ack);
    bus_restart();
    chk("lit_busy_rs", 32'(bus_if.busy), 32'd1);
    dbuf[0] = 8'hC3;
    bus_if.tx_byte = dbuf[0];
    send_addr(Slv, 1'b1, ack);
    exp_txreq += 1;
    read_body(1);
    bus_stop();
    chk("lit_rs_rx_byte", 32'(bus_if.rx_byte), 32'h11);
    chk("lit_rs_read", 32'(rd_got[0]), 32'hC3);

    // STOP after 4 data bits: rx_byte unchanged, no pulse.
    rx0 = rx_seen;
    bus_start();
    send_addr(Slv, 1'b0, ack);
    write_partial(8'hA5, 4);
    bus_stop();
    chk("lit_abort_rx", 32'(rx_seen - rx0), 32'd0);
    chk("lit_abort_rx_byte", 32'(bus_if.rx_byte), 32'h11);

    // Reset while the target pulls the address ACK.
    bus_start();
    busy_chk = 1'b0;
    b = 8'hA0;
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], 1'b0, s);
    slave_window = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    chk("ack_before_reset", 32'(sda), 32'd0);
    #2;
    arstn = 1'b0;
    rx_exp_q.delete();
    m_rx_last = 8'h00;  m_busy = 1'b0;  slave_window = 1'b0;
    #1;
    chk("mid_rst_sda", 32'(sda), 32'd1);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    chk("mid_rst_tx_req", 32'(bus_if.tx_req), 32'd0);
    chk("mid_rst_rx_byte", 32'(bus_if.rx_byte), 32'h00);
    wait_clk(2);
    arstn = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    bus_stop();
    bus_start();
    send_addr(Slv, 1'b0, ack);
    chk("lit_post_rst_ack", 32'(ack), 32'd1);
    write_byte(8'h77, 1'b1, ack);
    bus_stop();
    chk("lit_post_rst_rx", 32'(bus_if.rx_byte), 32'h77);

    for (int t = 0; t < 16; t++) rand_txn();

    chk("final_tx_req_count", 32'(txreq_seen), 32'(exp_txreq));
    chk("final_rx_drained", 32'(rx_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
